// File: rtl/reward_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : reward_scheduler_if
//  Description : Bundle of requester, engine and result signals shared by the
//                reward scheduler and its environment.
//                  master : scheduler side (drives acks, engine launch,
//                           captured fields and the result)
//                  slave  : environment side (requesters, engine, result sink)
//                Signals:
//                  req[N_REQ], req_pkt[N_REQ*5*WORD_WIDTH]  requests and packets
//                  req_ack[N_REQ]                           one-hot capture pulse
//                  eng_en, eng_<field>[WORD_WIDTH]          engine launch + fields
//                  eng_done, eng_reward[WORD_WIDTH]         engine completion
//                  res_valid, res_reward, res_id, res_timeout, busy
//  Revision    : 1.0 - initial release
// ============================================================================
interface reward_scheduler_if #(
    parameter int WORD_WIDTH = 16,
    parameter int N_REQ      = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]              req;
    logic [N_REQ*5*WORD_WIDTH-1:0] req_pkt;
    logic [N_REQ-1:0]              req_ack;
    logic                          eng_en;
    logic [WORD_WIDTH-1:0]         eng_sourceID;
    logic [WORD_WIDTH-1:0]         eng_batteryStat;
    logic [WORD_WIDTH-1:0]         eng_Value;
    logic [WORD_WIDTH-1:0]         eng_clusterID;
    logic [WORD_WIDTH-1:0]         eng_destinationID;
    logic                          eng_done;
    logic [WORD_WIDTH-1:0]         eng_reward;
    logic                          res_valid;
    logic [WORD_WIDTH-1:0]         res_reward;
    logic [ID_W-1:0]               res_id;
    logic                          res_timeout;
    logic                          busy;

    modport master (
        input  req, req_pkt, eng_done, eng_reward,
        output req_ack, eng_en, eng_sourceID, eng_batteryStat, eng_Value,
               eng_clusterID, eng_destinationID,
               res_valid, res_reward, res_id, res_timeout, busy
    );

    modport slave (
        output req, req_pkt, eng_done, eng_reward,
        input  req_ack, eng_en, eng_sourceID, eng_batteryStat, eng_Value,
               eng_clusterID, eng_destinationID,
               res_valid, res_reward, res_id, res_timeout, busy
    );
endinterface
`default_nettype wire

// File: rtl/reward_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : reward_scheduler
//  Description : Round-robin scheduler sharing one reward engine among N_REQ
//                requesters. Captures one packet, pulses eng_en, waits for
//                eng_done and returns the reward tagged with the requester id.
//  Ports       : clock - rising-edge clock
//                rst   - synchronous active-high reset
//                bus   - reward_scheduler_if.master (requests, engine, result)
//  Options     : SCHED_TIMEOUT_EN - enables the WAIT-state watchdog which
//                aborts after TIMEOUT_CYCLES cycles with res_timeout=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module reward_scheduler #(
    parameter int WORD_WIDTH     = 16,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic              clock,
    input  wire logic              rst,
    reward_scheduler_if.master     bus
);
    localparam int ID_W = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       win_idx;
    logic                  win_found;
    logic                  timeout_hit;
    logic                  finish_wait;
    int                    scan;

    logic [WORD_WIDTH-1:0] cap_source_id;
    logic [WORD_WIDTH-1:0] cap_battery_stat;
    logic [WORD_WIDTH-1:0] cap_value;
    logic [WORD_WIDTH-1:0] cap_cluster_id;
    logic [WORD_WIDTH-1:0] cap_destination_id;
    logic [WORD_WIDTH-1:0] res_reward_q;
    logic [ID_W-1:0]       res_id_q;
    logic                  res_timeout_q;

    // Round-robin search: walk N_REQ positions starting at ptr, first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = int'(ptr) + i;
            if (scan >= N_REQ) begin
                scan = scan - N_REQ;
            end
            if (!win_found && bus.req[ID_W'(scan)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(scan);
            end
        end
    end

    assign finish_wait = (state == S_WAIT) && (bus.eng_done || timeout_hit);

`ifdef SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // Cleared while in LAUNCH so the first WAIT cycle sees 0; the watchdog
    // fires in the TIMEOUT_CYCLES-th WAIT cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout_hit = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign bus.res_timeout = res_timeout_q;
`else
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYCLES == 0) ^ res_timeout_q;
    assign timeout_hit        = 1'b0;
    assign bus.res_timeout    = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; eng_done outside WAIT is simply not looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (win_found) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (bus.eng_done || timeout_hit) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Capture and result registers
    always_ff @(posedge clock) begin
        if (rst) begin
            ptr                <= '0;
            grant_idx          <= '0;
            cap_source_id      <= '0;
            cap_battery_stat   <= '0;
            cap_value          <= '0;
            cap_cluster_id     <= '0;
            cap_destination_id <= '0;
            res_reward_q       <= '0;
            res_id_q           <= '0;
            res_timeout_q      <= 1'b0;
        end else begin
            if (state == S_IDLE && win_found) begin
                grant_idx          <= win_idx;
                ptr                <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                cap_source_id      <= bus.req_pkt[(int'(win_idx)*5 + 0)*WORD_WIDTH +: WORD_WIDTH];
                cap_battery_stat   <= bus.req_pkt[(int'(win_idx)*5 + 1)*WORD_WIDTH +: WORD_WIDTH];
                cap_value          <= bus.req_pkt[(int'(win_idx)*5 + 2)*WORD_WIDTH +: WORD_WIDTH];
                cap_cluster_id     <= bus.req_pkt[(int'(win_idx)*5 + 3)*WORD_WIDTH +: WORD_WIDTH];
                cap_destination_id <= bus.req_pkt[(int'(win_idx)*5 + 4)*WORD_WIDTH +: WORD_WIDTH];
            end
            if (finish_wait) begin
                // A real completion in the same cycle as the watchdog wins.
                res_reward_q  <= bus.eng_done ? bus.eng_reward : '0;
                res_id_q      <= grant_idx;
                res_timeout_q <= !bus.eng_done;
            end
        end
    end

    // Output decode
    always_comb begin
        bus.eng_en    = (state == S_LAUNCH);
        bus.req_ack   = (state == S_LAUNCH) ? (N_REQ'(1) << grant_idx) : '0;
        bus.res_valid = (state == S_DONE);
        bus.busy      = (state != S_IDLE);
    end

    assign bus.eng_sourceID      = cap_source_id;
    assign bus.eng_batteryStat   = cap_battery_stat;
    assign bus.eng_Value         = cap_value;
    assign bus.eng_clusterID     = cap_cluster_id;
    assign bus.eng_destinationID = cap_destination_id;
    assign bus.res_reward        = res_reward_q;
    assign bus.res_id            = res_id_q;
endmodule
`default_nettype wire

// File: tb/tb_reward_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reward_scheduler
//  Description : Self-checking bench for reward_scheduler: directed vector
//                table, hand sequences for fairness / reset / stale done /
//                watchdog, and randomized requests against a round-robin model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reward_scheduler;
    localparam int W = 16;
    localparam int N = 4;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    reward_scheduler_if #(.WORD_WIDTH(W), .N_REQ(N)) bus ();

    reward_scheduler #(.WORD_WIDTH(W), .N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int m_ptr = 0;
    logic [W-1:0] pkt [N][5];

    typedef struct {
        logic [N-1:0] mask;
        int           lat;
        logic [W-1:0] rwd;
        int           exp_id;
        bit           stale;
        bit           wd;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++)
            for (int f = 0; f < 5; f++)
                bus.req_pkt[(i*5+f)*W +: W] = pkt[i][f];
    endtask

    task automatic new_pkts();
        for (int i = 0; i < N; i++)
            for (int f = 0; f < 5; f++)
                pkt[i][f] = W'($urandom);
        pack();
    endtask

    // Reference arbitration: first requesting index at or after m_ptr.
    function automatic int rr_pick(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++)
            if (mask[(m_ptr + i) % N]) return (m_ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [79:0] outs_all();
        return {bus.busy, bus.req_ack, bus.eng_en, bus.res_valid, bus.res_timeout,
                bus.res_id, bus.res_reward, bus.eng_sourceID, bus.eng_batteryStat,
                bus.eng_Value, bus.eng_clusterID};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("reset_outputs", outs_all(), 80'd0);
        chk("reset_dest", bus.eng_destinationID, 80'd0);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // Wait (bounded) for req_ack; returns edges taken.
    task automatic wait_ack(output int n);
        n = 0;
        while (bus.req_ack == '0 && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic check_capture(input string tag, input int id);
        chk({tag, "_ack"}, bus.req_ack, 80'(1) << id);
        chk({tag, "_en"}, bus.eng_en, 80'd1);
        chk({tag, "_fields"},
            {bus.eng_destinationID, bus.eng_clusterID, bus.eng_Value,
             bus.eng_batteryStat, bus.eng_sourceID},
            {pkt[id][4], pkt[id][3], pkt[id][2], pkt[id][1], pkt[id][0]});
    endtask

    // One full transaction starting from IDLE (#1 after an edge).
    task automatic service(input vec_t v);
        int  n;
        bit  bad;
        bus.req = v.mask;
        wait_ack(n);
        chk("ack_latency", n, 80'd1);
        check_capture("cap", v.exp_id);
        m_ptr = (v.exp_id + 1) % N;
        bus.req = '0;
        if (v.stale) begin
            bus.eng_done   = 1'b1;
            bus.eng_reward = 16'hDEAD;
        end
        bad = 1'b0;
        for (int c = 0; c < v.lat; c++) begin
            @(posedge clock); #1;
            bus.eng_done = 1'b0;
            if (bus.res_valid || bus.eng_en || bus.req_ack != '0 || !bus.busy) bad = 1'b1;
            if (v.wd && c == 0) bus.req = ~v.mask;
        end
        bus.req = '0;
        chk("wait_quiet", bad, 80'd0);
        bus.eng_done   = 1'b1;
        bus.eng_reward = v.rwd;
        @(posedge clock); #1;
        bus.eng_done   = 1'b0;
        bus.eng_reward = W'($urandom);
        chk("res_valid", bus.res_valid, 80'd1);
        chk("res_id", bus.res_id, 80'(v.exp_id));
        chk("res_reward", bus.res_reward, 80'(v.rwd));
        chk("res_timeout", bus.res_timeout, 80'd0);
        @(posedge clock); #1;
        chk("post_idle", {bus.res_valid, bus.busy, bus.res_reward}, {2'b00, v.rwd});
        if (v.wd) begin
            bad = 1'b0;
            repeat (3) begin
                @(posedge clock); #1;
                if (bus.busy || bus.req_ack != '0) bad = 1'b1;
            end
            chk("withdrawn_not_granted", bad, 80'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        int  n, extra, id;
        bit  bad;
        vec_t v;
        logic [N-1:0] mask;

        bus.req = '0;
        bus.eng_done = 1'b0;
        bus.eng_reward = '0;
        new_pkts();

        tbl[0] = '{4'b0001, 5, 16'h1234, 0, 0, 0};
        tbl[1] = '{4'b0001, 1, 16'h0001, 0, 1, 0};
        tbl[2] = '{4'b0110, 2, 16'hA5A5, 1, 0, 0};
        tbl[3] = '{4'b0110, 3, 16'h5A5A, 2, 1, 1};
        tbl[4] = '{4'b1000, 4, 16'hFFFF, 3, 0, 0};
        tbl[5] = '{4'b1001, 1, 16'h0F0F, 0, 0, 0};
        tbl[6] = '{4'b1001, 6, 16'h1111, 3, 0, 1};
        tbl[7] = '{4'b0100, 2, 16'h2222, 2, 1, 0};
        tbl[8] = '{4'b0011, 3, 16'h3333, 0, 0, 0};
        tbl[9] = '{4'b1010, 1, 16'h4444, 1, 0, 0};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            new_pkts();
            if (i == 0) begin
                pkt[0][0] = 16'd15;   pkt[0][1] = 16'h5999; pkt[0][2] = 16'h0680;
                pkt[0][3] = 16'd1;    pkt[0][4] = 16'd3;
                pack();
            end
            service(tbl[i]);
        end

        // Fairness: all requesters held continuously.
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(n);
            check_capture("fair", k % 4);
            extra = 0;
            repeat (2) begin
                @(posedge clock); #1;
                if (bus.req_ack != '0) extra++;
            end
            bus.eng_done = 1'b1;
            bus.eng_reward = 16'(16'h100 + k);
            @(posedge clock); #1;
            bus.eng_done = 1'b0;
            if (bus.req_ack != '0) extra++;
            chk("fair_res_id", {bus.res_valid, bus.res_id}, {1'b1, 2'(k % 4)});
            chk("fair_single_ack", extra, 80'd0);
        end
        bus.req = '0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        m_ptr = 1;
        // A grant may have fired on the last IDLE edge; drain it if so.
        if (bus.busy) begin
            do_reset();
        end

        // Reset in the middle of WAIT.
        m_ptr = 1;
        do_reset();
        v = '{4'b0001, 2, 16'h9999, 0, 0, 0};
        service(v);
        bus.req = 4'b0100;
        wait_ack(n);
        check_capture("rstw", rr_pick(4'b0100));
        bus.req = '0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        rst = 1'b1;
        @(posedge clock); #1;
        rst = 1'b0;
        m_ptr = 0;
        chk("rstw_outputs", outs_all(), 80'd0);
        bus.eng_done = 1'b1;
        bus.eng_reward = 16'h7777;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            bus.eng_done = 1'b0;
            if (bus.res_valid || bus.busy || bus.res_reward != '0) bad = 1'b1;
        end
        chk("rstw_late_done_ignored", bad, 80'd0);
        new_pkts();
        v = '{4'b1111, 2, 16'h0BAD, 0, 0, 0};
        service(v);

        // Stale done in IDLE with no request.
        bus.eng_done = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            if (bus.res_valid || bus.busy) bad = 1'b1;
        end
        bus.eng_done = 1'b0;
        chk("idle_done_ignored", bad, 80'd0);

`ifdef SCHED_TIMEOUT_EN
        // Watchdog: engine never answers.
        mask = 4'b0010;
        id = rr_pick(mask);
        bus.req = mask;
        wait_ack(n);
        check_capture("to", id);
        m_ptr = (id + 1) % N;
        bus.req = '0;
        n = 0;
        while (!bus.res_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("to_latency", n, 80'd9);
        chk("to_result", {bus.res_valid, bus.res_timeout, bus.res_id, bus.res_reward},
            {1'b1, 1'b1, 2'(id), 16'h0000});
        @(posedge clock); #1;
        bus.eng_done = 1'b1;
        bus.eng_reward = 16'h5555;
        bad = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
            if (bus.res_valid || bus.busy) bad = 1'b1;
        end
        bus.eng_done = 1'b0;
        chk("to_late_done_ignored", {bad, bus.res_timeout}, {1'b0, 1'b1});

        // Done on the final WAIT cycle beats the watchdog.
        mask = 4'b0001;
        id = rr_pick(mask);
        bus.req = mask;
        wait_ack(n);
        m_ptr = (id + 1) % N;
        bus.req = '0;
        repeat (8) begin
            @(posedge clock); #1;
        end
        chk("tie_still_waiting", {bus.busy, bus.res_valid}, {1'b1, 1'b0});
        bus.eng_done = 1'b1;
        bus.eng_reward = 16'h4242;
        @(posedge clock); #1;
        bus.eng_done = 1'b0;
        chk("tie_result", {bus.res_valid, bus.res_timeout, bus.res_id, bus.res_reward},
            {1'b1, 1'b0, 2'(id), 16'h4242});
        @(posedge clock); #1;
`else
        // Without the watchdog, WAIT is held indefinitely.
        mask = 4'b0010;
        id = rr_pick(mask);
        bus.req = mask;
        wait_ack(n);
        check_capture("hold", id);
        m_ptr = (id + 1) % N;
        bus.req = '0;
        bad = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.res_valid || !bus.busy) bad = 1'b1;
        end
        chk("hold_wait", bad, 80'd0);
        bus.eng_done = 1'b1;
        bus.eng_reward = 16'hC0DE;
        @(posedge clock); #1;
        bus.eng_done = 1'b0;
        chk("hold_result", {bus.res_valid, bus.res_timeout, bus.res_id, bus.res_reward},
            {1'b1, 1'b0, 2'(id), 16'hC0DE});
        @(posedge clock); #1;
`endif

        // Randomized traffic against the round-robin model.
        for (int r = 0; r < 25; r++) begin
            new_pkts();
            mask = N'($urandom_range(1, 15));
            v.mask   = mask;
            v.lat    = $urandom_range(1, 6);
            v.rwd    = W'($urandom);
            v.exp_id = rr_pick(mask);
            v.stale  = $urandom_range(0, 1) == 1;
            v.wd     = $urandom_range(0, 1) == 1;
            service(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reward_scheduler.md
# reward_scheduler

Round-robin scheduler that shares the single reward-computation engine (the Q-learning `top` datapath) among `N_REQ` packet requesters. It captures one neighbour packet at a time (source ID, battery status, value, cluster ID, destination ID) and launches the engine with a one-cycle enable. It then waits for `done_reward` and returns the reward tagged with the requester index. An optional watchdog recovers from an engine that never completes.

## Interface
- `WORD_WIDTH`, 16: width of every packet field and of the reward.
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 255: WAIT-state cycles before abort; only used with `SCHED_TIMEOUT_EN`.
- `clock` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N_REQ: per-requester request. Held high, with its fields stable, until the matching `req_ack`.
- `req_pkt` input N_REQ*5*WORD_WIDTH: flattened packets. Requester i occupies slice i. Fields within a slice, LSB first: sourceID, batteryStat, Value, clusterID, destinationID.
- `req_ack` output N_REQ: one-hot, one-cycle pulse when a packet is captured.
- `eng_en` output 1: one-cycle launch pulse to the engine.
- `eng_sourceID`, `eng_batteryStat`, `eng_Value`, `eng_clusterID`, `eng_destinationID` output WORD_WIDTH each: captured fields, held stable from capture until return to IDLE.
- `eng_done` input 1: engine `done_reward`.
- `eng_reward` input WORD_WIDTH: engine `reward_out`, valid while `eng_done`.
- `res_valid` output 1: one-cycle result strobe. There is no backpressure.
- `res_reward` output WORD_WIDTH: reward, or 0 on timeout.
- `res_id` output clog2(N_REQ): index of the serviced requester.
- `res_timeout` output 1: qualifies `res_valid`; result produced by the watchdog.
- `busy` output 1: high in every state except IDLE.

## Operation
- **States:**
  - IDLE: sample `req` and pick a winner by round-robin; if `req`==0, stay.
  - LAUNCH: exactly one cycle; `eng_en`=1.
  - WAIT: wait for `eng_done`.
  - DONE: exactly one cycle; `res_valid`=1.
- **Transitions:**
  - IDLE → LAUNCH: any `req` bit set. At that edge, latch the winner's fields, winner index and `req_ack` bit.
  - LAUNCH → WAIT: unconditional.
  - WAIT → DONE: `eng_done`=1. Latch `eng_reward` into `res_reward`.
  - DONE → IDLE: unconditional.
- **Round-robin:**
  - Priority pointer `ptr` resets to 0.
  - The search starts at `ptr` and increments modulo N_REQ; the first set `req` bit wins.
  - After a grant to index g, `ptr`=(g+1) mod N_REQ.
- **Withdrawal:** a requester dropping `req` before it is sampled in IDLE is never granted.
- **Stale `eng_done`:** ignored in IDLE, LAUNCH and DONE. Only WAIT consumes it.
- **Repeat requests:** a requester still asserting `req` after its ack is treated as a new request.
- **Reset (any state, including mid-WAIT):**
  - Next cycle: state=IDLE, `ptr`=0.
  - Outputs: all zero, including the `eng_*` field registers and `res_*`.
  - A reward arriving after reset is ignored.

## Timing
- Reset values: `req_ack`=0, `eng_en`=0, all `eng_*` fields=0, `res_valid`=0, `res_reward`=0, `res_id`=0, `res_timeout`=0, `busy`=0.
- Request to ack: `req` sampled high at edge k gives `req_ack`, `eng_en` and valid `eng_*` fields in cycle k+1.
- Done to result: `eng_done` sampled at edge m gives `res_valid` in cycle m+1.
- Minimum service time, `req` to `res_valid`: 3 cycles, reached when `eng_done` arrives in the first WAIT cycle.
- Throughput: one packet per (engine latency + 3) cycles. IDLE lasts at least one cycle between packets.
- `res_reward`, `res_id` and `res_timeout` hold their values until the next DONE.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no `eng_done`, go to DONE with `res_timeout`=1 and `res_reward`=0.
  - `eng_done` and the timeout in the same cycle: done wins, `res_timeout`=0.
- `SCHED_TIMEOUT_EN` undefined:
  - No counter; WAIT is held indefinitely.
  - `res_timeout` is tied to 0.

## Test plan
- **Single packet:** `req`=0001 with fields 15, 0x5999, 0x0680, 1, 3; engine model returns 0x1234 five cycles after `eng_en`.
  - Expect `req_ack`=0001 and one `eng_en` pulse with those exact fields.
  - Expect `res_valid` with `res_reward`=0x1234, `res_id`=0.
- **Fairness:** all four `req` held continuously.
  - Grants follow order 0,1,2,3,0.
  - Each `res_id` matches its grant; exactly one ack per service.
- **Pointer wrap:** grant 3, then `req`=1001 → next grant is index 0, `ptr`=1.
- **Reset mid-WAIT:** `rst` is pulsed 2 cycles after `eng_en`, and `eng_done` arrives afterwards.
  - Expect `busy`=0, no `res_valid`, all outputs zero.
  - Next grant is from `ptr`=0.
- **Timeout (macro on, `TIMEOUT_CYCLES`=8):** engine never responds → `res_valid` with `res_timeout`=1 and `res_reward`=0, 8 WAIT cycles after LAUNCH. A late `eng_done` in IDLE is ignored.
- **Done/timeout tie:** `eng_done` arrives on the 8th WAIT cycle → `res_timeout`=0 and the reward is passed through.
